// File: rtl/sumador_pkg.sv
// sumador_pkg: shared state encoding and default operand width for the sumador datapath.
package sumador_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fulladder.sv
// fulladder: single-bit full adder cell, the only arithmetic element of the serial engine.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic c_o,
    output logic res_o
);

    assign res_o = a_i ^ b_i ^ c_i;
    assign c_o   = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract, one fulladder reused LSB-first over WIDTH cycles.
module serial_add_ctrl
    import sumador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             fa_c, fa_res;

    fulladder u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (c_q),
        .c_o  (fa_c),
        .res_o(fa_res)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start_i) begin
                a_d     = a_i;
                b_d     = sub_i ? ~b_i : b_i;
                c_d     = sub_i | cin_i;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {fa_res, res_q[WIDTH-1:1]};
                c_d   = fa_c;
                cnt_d = cnt_q + 1'b1;
                // c_q is the carry into the MSB on the final bit
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = res_d;
                    cout_d  = fa_c;
                    ovf_d   = c_q ^ fa_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of serial_add_ctrl against an arithmetic model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic         sub_i = 1'b0;
    logic         cin_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy_o, done_o, cout_o, ovf_o;
    logic [W-1:0] sum_o;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start_i(start_i),
        .sub_i  (sub_i),
        .cin_i  (cin_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .sum_o  (sum_o),
        .cout_o (cout_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cycle++;

    // Returns {ovf, cout, sum} from integer arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int ur = sub ? ua - ub : ua + ub + int'(cin);
        int sr = sub ? sa - sb : sa + sb + int'(cin);
        logic c = sub ? (ua >= ub) : (ur >= (1 << W));
        logic v = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        logic [W-1:0] s = W'(ur);
        return {v, c, s};
    endfunction

    // Drives one request at the current negedge; returns after the done cycle is sampled.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, output int lat, output logic [W+1:0] res);
        a_i = a; b_i = b; cin_i = cin; sub_i = sub; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        lat = -1;
        res = '0;
        for (int i = 1; i <= 4 * W; i++) begin
            if (done_o) begin
                lat = i;
                res = {ovf_o, cout_o, sum_o};
                break;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        vectors++;
        if ({busy_o, done_o, sum_o, cout_o, ovf_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy_o, done_o, sum_o, cout_o, ovf_o);
        end
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        vectors++;
        if ({busy_o, done_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] va[4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
        logic [W-1:0] vb[4] = '{8'h33, 8'h01, 8'h20, 8'h01};
        logic         vc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W+1:0] want[4] = '{{2'b10, 8'h8D}, {2'b01, 8'h01}, {2'b00, 8'hF0}, {2'b11, 8'h7F}};
        logic [W+1:0] got;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], vs[i], lat, got);
            vectors++;
            if (lat !== W + 1) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, want %0d", i, lat, W + 1);
            end
            vectors++;
            if (got !== want[i]) begin
                miscompares++;
                $display("FAIL directed_result[%0d]: got ovf,cout,sum=%h, want %h", i, got, want[i]);
            end
            @(negedge clk_i);
            vectors++;
            if ({busy_o, done_o} !== 2'b00) begin
                miscompares++;
                $display("FAIL done_pulse[%0d]: got busy=%b done=%b after done, want 0 0",
                         i, busy_o, done_o);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic         cin, sub;
        logic [W+1:0] got, want;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            want = model(a, b, cin, sub);
            run_op(a, b, cin, sub, lat, got);
            vectors++;
            if (got !== want || lat !== W + 1) begin
                miscompares++;
                $display("FAIL random[%0d] a=%h b=%h cin=%b sub=%b: got %h lat %0d, want %h lat %0d",
                         i, a, b, cin, sub, got, lat, want, W + 1);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end
    endtask

    task automatic test_ignored_start;
        logic [W+1:0] want = model(8'h3C, 8'h15, 1'b0, 1'b0);
        int dones = 0;
        a_i = 8'h3C; b_i = 8'h15; cin_i = 1'b0; sub_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ignored_busy: got busy=%b, want 1", busy_o);
        end
        a_i = 8'hF0; b_i = 8'h0F; sub_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            if (done_o) begin
                dones++;
                vectors++;
                if ({ovf_o, cout_o, sum_o} !== want) begin
                    miscompares++;
                    $display("FAIL ignored_result: got %h, want %h", {ovf_o, cout_o, sum_o}, want);
                end
            end
            @(negedge clk_i);
        end
        vectors++;
        if (dones !== 1 || busy_o !== 1'b0 || {ovf_o, cout_o, sum_o} !== want) begin
            miscompares++;
            $display("FAIL ignored_single_done: got %0d done pulses busy=%b held=%h, want 1 0 %h",
                     dones, busy_o, {ovf_o, cout_o, sum_o}, want);
        end
    endtask

    task automatic test_back_to_back;
        logic [W+1:0] got1, got2;
        int lat1, lat2, t1, t2;
        run_op(8'h11, 8'h22, 1'b1, 1'b0, lat1, got1);
        t1 = cycle;
        @(negedge clk_i);
        run_op(8'h05, 8'h09, 1'b0, 1'b1, lat2, got2);
        t2 = cycle;
        vectors++;
        if (got1 !== model(8'h11, 8'h22, 1'b1, 1'b0) || got2 !== model(8'h05, 8'h09, 1'b0, 1'b1)) begin
            miscompares++;
            $display("FAIL b2b_results: got %h %h, want %h %h", got1, got2,
                     model(8'h11, 8'h22, 1'b1, 1'b0), model(8'h05, 8'h09, 1'b0, 1'b1));
        end
        vectors++;
        if (lat1 < 0 || lat2 < 0 || t2 - t1 !== W + 2) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles between dones, want %0d", t2 - t1, W + 2);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [W+1:0] got;
        int lat;
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, lat, got);
        @(negedge clk_i);
        a_i = 8'h77; b_i = 8'h66; cin_i = 1'b0; sub_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        vectors++;
        if ({busy_o, done_o, sum_o, cout_o, ovf_o} !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy_o, done_o, sum_o, cout_o, ovf_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, lat, got);
        vectors++;
        if (got !== {2'b00, 8'h02} || lat !== W + 1) begin
            miscompares++;
            $display("FAIL after_reset_op: got %h lat %0d, want 002 lat %0d", got, lat, W + 1);
        end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
